// File: rtl/tomasulo_reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_reg_file_if
//  Description : Bus bundle for the Tomasulo register file. Groups the preload,
//                issue (rename), CDB, flush and operand-read signals.
//                master : the issue/dispatch side driving requests
//                slave  : the register file itself
//  Signals     : load_en/load_addr/load_data     preload write
//                issue_en/issue_dest/issue_tag   rename destination register
//                cdb_valid/cdb_tag/cdb_data      common data bus broadcast
//                flush                           drop all rename state
//                rd_addr_*/rd_data_*/rd_busy_*/rd_tag_*  two operand ports
//                busy_count                      number of renamed registers
//  Revision    : 1.0 - initial release
// ============================================================================
interface tomasulo_reg_file_if #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 10,
    parameter int TAG_W    = 3,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_dest;
    logic [TAG_W-1:0]  issue_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              flush;

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;
    logic [TAG_W-1:0]  rd_tag_a;
    logic [TAG_W-1:0]  rd_tag_b;

    logic [CNT_W-1:0]  busy_count;

    modport master (
        output load_en, load_addr, load_data,
        output issue_en, issue_dest, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output flush,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_tag_a, rd_tag_b,
        input  busy_count
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  issue_en, issue_dest, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  flush,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_tag_a, rd_tag_b,
        output busy_count
    );
endinterface
`default_nettype wire

// File: rtl/tomasulo_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tomasulo_reg_file
//  Description : Architectural register file with per-register rename status
//                (busy bit + producer tag Qi). Captures CDB results by tag,
//                accepts renames from issue, and serves two combinational
//                read ports with same-cycle CDB forwarding.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-low reset
//                bus    - tomasulo_reg_file_if.slave (preload, issue, CDB,
//                         flush, two read ports, busy_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module tomasulo_reg_file #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 10,
    parameter int TAG_W    = 3,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input wire logic              clock,
    input wire logic              reset,
    tomasulo_reg_file_if.slave    bus
);

    localparam int c_cnt_w = $clog2(NUM_REGS + 1);

    // Architectural state
    logic [DATA_W-1:0]   r_value [NUM_REGS];
    logic [TAG_W-1:0]    r_qi    [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [c_cnt_w-1:0]  r_busy_count;

    // Next-state
    logic [DATA_W-1:0]   w_value_nxt [NUM_REGS];
    logic [TAG_W-1:0]    w_qi_nxt    [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [c_cnt_w-1:0]  w_busy_count_nxt;

    // Registers whose pending producer is broadcasting this cycle
    logic [NUM_REGS-1:0] w_cdb_hit;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cdb_hit[i] = r_busy[i] && bus.cdb_valid && (r_qi[i] == bus.cdb_tag);
        end
    end

    // Per-register update, applied lowest to highest priority:
    // CDB capture, then flush / issue, then preload.
    always_comb begin
        w_busy_count_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_value_nxt[i] = r_value[i];
            w_qi_nxt[i]    = r_qi[i];
            w_busy_nxt[i]  = r_busy[i];

            if (w_cdb_hit[i]) begin
                w_value_nxt[i] = bus.cdb_data;
                w_busy_nxt[i]  = 1'b0;
                w_qi_nxt[i]    = '0;
            end

            // A rename colliding with a capture keeps the captured (stale)
            // value but stays busy on the newer producer.
            if (bus.flush) begin
                w_busy_nxt[i] = 1'b0;
                w_qi_nxt[i]   = '0;
            end else if (bus.issue_en && (bus.issue_dest == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
                w_qi_nxt[i]   = bus.issue_tag;
            end

            if (bus.load_en && (bus.load_addr == ADDR_W'(i))) begin
                w_value_nxt[i] = bus.load_data;
                w_busy_nxt[i]  = 1'b0;
                w_qi_nxt[i]    = '0;
            end

            w_busy_count_nxt = w_busy_count_nxt + c_cnt_w'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value      <= '{default: '0};
            r_qi         <= '{default: '0};
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_value      <= w_value_nxt;
            r_qi         <= w_qi_nxt;
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_count_nxt;
        end
    end

    // Read ports see the state before the edge; a same-cycle issue is not
    // visible, but a same-cycle CDB hit is forwarded as a ready operand.
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];
    logic [TAG_W-1:0]  w_rd_tag  [2];

    assign w_rd_addr[0] = bus.rd_addr_a;
    assign w_rd_addr[1] = bus.rd_addr_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
            w_rd_tag[p]  = '0;
            if (int'(w_rd_addr[p]) < NUM_REGS) begin
                if (!r_busy[w_rd_addr[p]]) begin
                    w_rd_data[p] = r_value[w_rd_addr[p]];
                end else if (w_cdb_hit[w_rd_addr[p]]) begin
                    w_rd_data[p] = bus.cdb_data;
                end else begin
                    w_rd_data[p] = r_value[w_rd_addr[p]];
                    w_rd_busy[p] = 1'b1;
                    w_rd_tag[p]  = r_qi[w_rd_addr[p]];
                end
            end
        end
    end

    assign bus.rd_data_a  = w_rd_data[0];
    assign bus.rd_busy_a  = w_rd_busy[0];
    assign bus.rd_tag_a   = w_rd_tag[0];
    assign bus.rd_data_b  = w_rd_data[1];
    assign bus.rd_busy_b  = w_rd_busy[1];
    assign bus.rd_tag_b   = w_rd_tag[1];
    assign bus.busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tomasulo_reg_file
//  Description : Scoreboard bench for tomasulo_reg_file. The stimulus process
//                predicts read-port and busy_count values from an array-based
//                reference model and queues them; a monitor pops and compares
//                once per cycle, between clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tomasulo_reg_file;

    // Six registers on a 3-bit index so indices 6 and 7 are out of range.
    localparam int NUM_REGS = 6;
    localparam int DATA_W   = 10;
    localparam int TAG_W    = 3;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    tomasulo_reg_file_if #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .ADDR_W   (ADDR_W)
    ) bus ();

    tomasulo_reg_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int da; int ba; int ta;
        int db; int bb; int tb;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arrays of the architectural state.
    int m_val  [NUM_REGS];
    bit m_busy [NUM_REGS];
    int m_qi   [NUM_REGS];

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_qi[i] = 0;
        end
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NUM_REGS; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic void model_read(input int addr, input bit cv, input int ct, input int cd,
                                       output int d, output int b, output int t);
        d = 0; b = 0; t = 0;
        if (addr < NUM_REGS) begin
            if (!m_busy[addr])                     d = m_val[addr];
            else if (cv && m_qi[addr] == ct)       d = cd;
            else begin d = m_val[addr]; b = 1; t = m_qi[addr]; end
        end
    endfunction

    function automatic void model_update(input bit le, input int la, input int ld,
                                         input bit ie, input int id, input int it,
                                         input bit cv, input int ct, input int cd,
                                         input bit fl);
        int nv [NUM_REGS];
        bit nb [NUM_REGS];
        int nq [NUM_REGS];
        nv = m_val; nb = m_busy; nq = m_qi;
        for (int i = 0; i < NUM_REGS; i++)
            if (m_busy[i] && cv && m_qi[i] == ct) begin nv[i] = cd; nb[i] = 0; end
        if (fl) begin
            for (int i = 0; i < NUM_REGS; i++) begin nb[i] = 0; nq[i] = 0; end
        end else if (ie && id < NUM_REGS) begin
            nb[id] = 1; nq[id] = it;
        end
        if (le && la < NUM_REGS) begin nv[la] = ld; nb[la] = 0; end
        m_val = nv; m_busy = nb; m_qi = nq;
    endfunction

    function automatic void drive_idle();
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.issue_en = 1'b0; bus.issue_dest = '0; bus.issue_tag = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.flush = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    endfunction

    // One clock of stimulus: drive at the falling edge, queue the prediction,
    // advance the model just after the rising edge.
    task automatic step(input bit le, input int la, input int ld,
                        input bit ie, input int id, input int it,
                        input bit cv, input int ct, input int cd,
                        input bit fl, input int ra, input int rb);
        exp_t e;
        @(negedge clock);
        bus.load_en = le;   bus.load_addr = ADDR_W'(la);  bus.load_data = DATA_W'(ld);
        bus.issue_en = ie;  bus.issue_dest = ADDR_W'(id); bus.issue_tag = TAG_W'(it);
        bus.cdb_valid = cv; bus.cdb_tag = TAG_W'(ct);     bus.cdb_data = DATA_W'(cd);
        bus.flush = fl;     bus.rd_addr_a = ADDR_W'(ra);  bus.rd_addr_b = ADDR_W'(rb);
        model_read(ra, cv, ct, cd, e.da, e.ba, e.ta);
        model_read(rb, cv, ct, cd, e.db, e.bb, e.tb);
        e.cnt = model_count();
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        model_update(le, la, ld, ie, id, it, cv, ct, cd, fl);
    endtask

    task automatic idle_read(input int ra, input int rb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data_a",  int'(bus.rd_data_a),  e.da);
                chk("rd_busy_a",  int'(bus.rd_busy_a),  e.ba);
                chk("rd_tag_a",   int'(bus.rd_tag_a),   e.ta);
                chk("rd_data_b",  int'(bus.rd_data_b),  e.db);
                chk("rd_busy_b",  int'(bus.rd_busy_b),  e.bb);
                chk("rd_tag_b",   int'(bus.rd_tag_b),   e.tb);
                chk("busy_count", int'(bus.busy_count), e.cnt);
            end
        end
    end

    initial begin
        int ct;
        int r;
        drive_idle();
        model_clear();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;

        // Reset state
        idle_read(0, 5);

        // Preload and read
        step(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_read(1, 2);

        // Rename then capture with forwarding
        step(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 1, 2);
        idle_read(0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 3, 15, 0, 0, 1);
        idle_read(0, 1);

        // Multi-match and mismatch
        step(0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 5, 33, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 2, 7, 0, 1, 2);
        idle_read(1, 2);

        // Issue + CDB collision on the same register
        step(0, 0, 0, 1, 2, 4, 0, 0, 0, 0, 2, 1);
        step(0, 0, 0, 1, 2, 6, 1, 4, 9, 0, 2, 1);
        idle_read(2, 1);

        // Flush with three busy registers; issue in the flush cycle is ignored
        step(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 2, 3);
        step(0, 0, 0, 1, 4, 5, 0, 0, 0, 0, 3, 4);
        step(0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 3, 4);
        idle_read(2, 0);

        // Precedence: load > issue > capture on R5
        step(0, 0, 0, 1, 5, 7, 0, 0, 0, 0, 5, 4);
        step(1, 5, 1, 1, 5, 1, 1, 7, 300, 0, 5, 4);
        idle_read(5, 4);

        // Out-of-range indices: reads give zero, writes ignored
        step(1, 6, 99, 1, 7, 3, 0, 0, 0, 0, 6, 7);
        idle_read(6, 7);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ct = int'($urandom_range(0, 7));
            r  = int'($urandom_range(0, NUM_REGS - 1));
            if ($urandom_range(0, 2) != 0 && m_busy[r]) ct = m_qi[r];
            step($urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, ct, int'($urandom_range(0, 1023)),
                 $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // Asynchronous reset in the middle of a cycle with activity in flight
        step(1, 2, 77, 1, 4, 6, 0, 0, 0, 0, 2, 4);
        @(negedge clock);
        bus.issue_en = 1'b1; bus.issue_dest = 3'd3; bus.issue_tag = 3'd2;
        bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd4;
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("async_rst_data_a",  int'(bus.rd_data_a),  0);
        chk("async_rst_busy_b",  int'(bus.rd_busy_b),  0);
        chk("async_rst_tag_b",   int'(bus.rd_tag_b),   0);
        chk("async_rst_count",   int'(bus.busy_count), 0);
        @(posedge clock);
        #1;
        chk("rst_held_busy_b",   int'(bus.rd_busy_b),  0);
        @(negedge clock);
        drive_idle();
        #1 reset = 1'b1;

        // State after reset release
        idle_read(2, 3);
        idle_read(4, 5);

        repeat (2) @(negedge clock);
        #5;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
